// File: rtl/if_id_stage.sv
// IF/ID stage: aligns 1-cycle-latency ROM data with the PC that addressed it,
// parks responses that arrive while ID is stalled in a small skid FIFO, and
// presents {pc, inst, valid} to the decode stage. Handles bubbles and flush.
module if_id_stage #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic [DATA_W-1:0] rom_data_i,
    input  logic [5:0]        stall,
    input  logic              flush,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o,
    output logic              id_valid_o,
    output logic              stallreq_o,
    output logic              overflow_o
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SKID_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SKID_DEPTH);
    localparam logic [CNT_W-1:0] CNT_REQ  = CNT_W'(SKID_DEPTH - 1);

    // Circular pointer advance, wrapping at the last FIFO slot.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_LAST) begin
            n = PTR_ZERO;
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    // Fetch alignment state
    logic              ce_d_r;
    logic              stall0_d_r;
    logic              resp_v_r;
    logic [ADDR_W-1:0] resp_pc_r;

    // Skid FIFO state
    logic [ADDR_W-1:0] fifo_pc_r   [SKID_DEPTH];
    logic [DATA_W-1:0] fifo_inst_r [SKID_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic new_req_s;
    logic fifo_nonempty_s;
    logic fifo_full_s;
    logic push_s;
    logic pop_s;
    logic wr_en_s;
    logic stall_unused_s;

    // Stall bits above ID belong to later stages.
    assign stall_unused_s = ^stall[5:3];

    // A held PC (stall[0] last cycle with ce still high) is not a new fetch.
    assign new_req_s       = ce_i & (~ce_d_r | ~stall0_d_r) & ~flush;
    assign fifo_nonempty_s = (count_r != CNT_ZERO);
    assign fifo_full_s     = (count_r == CNT_FULL);
    // Once anything is parked, every later response must queue behind it.
    assign push_s          = resp_v_r & (stall[1] | fifo_nonempty_s);
    assign pop_s           = ~stall[1] & fifo_nonempty_s;
    // A push into a full FIFO only lands if the head leaves in the same cycle.
    assign wr_en_s         = push_s & (~fifo_full_s | pop_s);
    // One slot stays free for the response already in flight.
    assign stallreq_o      = (count_r >= CNT_REQ);

    // Register the fetch request so it lines up with next cycle's ROM data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_d_r     <= 1'b0;
            stall0_d_r <= 1'b0;
            resp_v_r   <= 1'b0;
            resp_pc_r  <= {ADDR_W{1'b0}};
        end else begin
            ce_d_r     <= ce_i;
            stall0_d_r <= stall[0];
            resp_v_r   <= new_req_s;
            resp_pc_r  <= pc_i;
        end
    end

    // Skid FIFO storage: write the aligned response at the tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                fifo_pc_r[i]   <= {ADDR_W{1'b0}};
                fifo_inst_r[i] <= {DATA_W{1'b0}};
            end
        end else if (!flush && wr_en_s) begin
            fifo_pc_r[wr_ptr_r]   <= resp_pc_r;
            fifo_inst_r[wr_ptr_r] <= rom_data_i;
        end
    end

    // Skid FIFO pointers and occupancy; flush empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow: a response was lost to a full FIFO; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_o <= 1'b0;
        end else if (!flush && push_s && fifo_full_s && !pop_s) begin
            overflow_o <= 1'b1;
        end
    end

    // IF/ID register: flush, bubble, hold, then FIFO head before live response.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            id_pc_o    <= {ADDR_W{1'b0}};
            id_inst_o  <= {DATA_W{1'b0}};
            id_valid_o <= 1'b0;
        end else if (stall[1] && !stall[2]) begin
            id_pc_o    <= {ADDR_W{1'b0}};
            id_inst_o  <= {DATA_W{1'b0}};
            id_valid_o <= 1'b0;
        end else if (stall[1]) begin
            id_pc_o    <= id_pc_o;
            id_inst_o  <= id_inst_o;
            id_valid_o <= id_valid_o;
        end else if (fifo_nonempty_s) begin
            id_pc_o    <= fifo_pc_r[rd_ptr_r];
            id_inst_o  <= fifo_inst_r[rd_ptr_r];
            id_valid_o <= 1'b1;
        end else if (resp_v_r) begin
            id_pc_o    <= resp_pc_r;
            id_inst_o  <= rom_data_i;
            id_valid_o <= 1'b1;
        end else begin
            id_pc_o    <= {ADDR_W{1'b0}};
            id_inst_o  <= {DATA_W{1'b0}};
            id_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a per-cycle vector table for fetch, stall,
// bubble and flush behaviour, then hand-written overflow and reset sequences.
// The instruction ROM returns 0x1000 + address one cycle after the address.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = 32'h0;
    logic        ce_i = 1'b0;
    logic [31:0] rom_data_i = 32'h0;
    logic [5:0]  stall = 6'b000000;
    logic        flush = 1'b0;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        stallreq_o;
    logic        overflow_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        ce;
        logic [31:0] pc;
        logic [5:0]  stall;
        logic        flush;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic        exp_sr;
        logic        exp_ov;
    } vec_t;

    vec_t vecs[$];

    if_id_stage #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .SKID_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .ce_i       (ce_i),
        .rom_data_i (rom_data_i),
        .stall      (stall),
        .flush      (flush),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_valid_o (id_valid_o),
        .stallreq_o (stallreq_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM model
    always @(posedge clk) rom_data_i <= 32'h1000 + pc_i;

    function automatic vec_t mk(input logic r, input logic c, input logic [31:0] p,
                                input logic [5:0] s, input logic f, input logic v,
                                input logic [31:0] ep, input logic sr, input logic ov);
        vec_t x;
        x.rst = r; x.ce = c; x.pc = p; x.stall = s; x.flush = f;
        x.exp_v = v; x.exp_pc = ep; x.exp_sr = sr; x.exp_ov = ov;
        return x;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then check all outputs.
    task automatic step(input string tag, input logic r, input logic c, input logic [31:0] p,
                        input logic [5:0] s, input logic f, input logic v,
                        input logic [31:0] ep, input logic sr, input logic ov);
        logic [31:0] exp_inst;
        @(negedge clk);
        rst = r; ce_i = c; pc_i = p; stall = s; flush = f;
        @(posedge clk);
        #1;
        exp_inst = v ? (32'h1000 + ep) : 32'h0;
        cmp({tag, " valid"},    {31'h0, id_valid_o}, {31'h0, v});
        cmp({tag, " pc"},       id_pc_o, ep);
        cmp({tag, " inst"},     id_inst_o, exp_inst);
        cmp({tag, " stallreq"}, {31'h0, stallreq_o}, {31'h0, sr});
        cmp({tag, " overflow"}, {31'h0, overflow_o}, {31'h0, ov});
    endtask

    initial begin
        // rst ce pc stall flush | valid pc stallreq overflow
        // Reset
        vecs.push_back(mk(1'b1, 1'b0, 32'd0,  6'b000000, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'd0,  6'b000000, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0));
        // T1: straight-line fetch, valid two cycles after ce
        vecs.push_back(mk(1'b0, 1'b1, 32'd0,  6'b000000, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd1,  6'b000000, 1'b0, 1'b1, 32'd0,  1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd2,  6'b000000, 1'b0, 1'b1, 32'd1,  1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd3,  6'b000000, 1'b0, 1'b1, 32'd2,  1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd4,  6'b000000, 1'b0, 1'b1, 32'd3,  1'b0, 1'b0));
        // T2: full stall at pc 5, hold pc 3 while 4 and 5 park, then 4,5,6
        vecs.push_back(mk(1'b0, 1'b1, 32'd5,  6'b000111, 1'b0, 1'b1, 32'd3,  1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd5,  6'b000111, 1'b0, 1'b1, 32'd3,  1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd5,  6'b000111, 1'b0, 1'b1, 32'd3,  1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd5,  6'b000000, 1'b0, 1'b1, 32'd4,  1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd6,  6'b000000, 1'b0, 1'b1, 32'd5,  1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd7,  6'b000000, 1'b0, 1'b1, 32'd6,  1'b0, 1'b0));
        // T3: one-cycle IF stall gives a bubble, then 7,8,9 in order
        vecs.push_back(mk(1'b0, 1'b1, 32'd8,  6'b000011, 1'b0, 1'b0, 32'd0,  1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd8,  6'b000000, 1'b0, 1'b1, 32'd7,  1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd9,  6'b000000, 1'b0, 1'b1, 32'd8,  1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd10, 6'b000000, 1'b0, 1'b1, 32'd9,  1'b0, 1'b0));
        // T4: park one entry with a response in flight, flush, redirect to 20
        vecs.push_back(mk(1'b0, 1'b1, 32'd11, 6'b000011, 1'b0, 1'b0, 32'd0,  1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd11, 6'b000000, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd20, 6'b000000, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd21, 6'b000000, 1'b0, 1'b1, 32'd20, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd22, 6'b000000, 1'b0, 1'b1, 32'd21, 1'b0, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("row%0d", i), vecs[i].rst, vecs[i].ce, vecs[i].pc, vecs[i].stall,
                 vecs[i].flush, vecs[i].exp_v, vecs[i].exp_pc, vecs[i].exp_sr, vecs[i].exp_ov);
        end

        // T5: ID held while the PC keeps advancing; the 3rd parked response is dropped
        step("t5_park1", 1'b0, 1'b1, 32'd23, 6'b000110, 1'b0, 1'b1, 32'd21, 1'b1, 1'b0);
        step("t5_park2", 1'b0, 1'b1, 32'd24, 6'b000110, 1'b0, 1'b1, 32'd21, 1'b1, 1'b0);
        step("t5_drop",  1'b0, 1'b1, 32'd25, 6'b000110, 1'b0, 1'b1, 32'd21, 1'b1, 1'b1);
        step("t5_drop2", 1'b0, 1'b0, 32'd25, 6'b000110, 1'b0, 1'b1, 32'd21, 1'b1, 1'b1);
        step("t5_pop22", 1'b0, 1'b0, 32'd25, 6'b000000, 1'b0, 1'b1, 32'd22, 1'b1, 1'b1);
        step("t5_pop23", 1'b0, 1'b0, 32'd25, 6'b000000, 1'b0, 1'b1, 32'd23, 1'b0, 1'b1);
        step("t5_idle",  1'b0, 1'b0, 32'd25, 6'b000000, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1);
        step("t5_flush", 1'b0, 1'b0, 32'd25, 6'b000000, 1'b1, 1'b0, 32'd0,  1'b0, 1'b1);

        // T6: fill the FIFO to 2 during a stall, reset, then restart from pc 0
        step("t6_req",   1'b0, 1'b1, 32'h30, 6'b000000, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1);
        step("t6_park1", 1'b0, 1'b1, 32'h31, 6'b000110, 1'b0, 1'b0, 32'd0,  1'b1, 1'b1);
        step("t6_park2", 1'b0, 1'b1, 32'h32, 6'b000110, 1'b0, 1'b0, 32'd0,  1'b1, 1'b1);
        step("t6_rst",   1'b1, 1'b1, 32'h32, 6'b000110, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0);
        step("t6_run0",  1'b0, 1'b1, 32'd0,  6'b000000, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0);
        step("t6_run1",  1'b0, 1'b1, 32'd1,  6'b000000, 1'b0, 1'b1, 32'd0,  1'b0, 1'b0);
        step("t6_run2",  1'b0, 1'b1, 32'd2,  6'b000000, 1'b0, 1'b1, 32'd1,  1'b0, 1'b0);
        step("t6_run3",  1'b0, 1'b1, 32'd3,  6'b000000, 1'b0, 1'b1, 32'd2,  1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
